bishop: RTL and testbench

// - Chess move-generator accelerator for a single bishop. Host programs a source board address, a destination

---
 rtl/bishop.sv | 153 +++++++++++++++
 tb/tb_bishop.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bishop.sv
// bishop: fetches a board over Avalon-MM, writes one board per legal bishop move, counts them
module bishop (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);
  typedef enum logic [2:0] {IDLE, FETCH, FWAIT, CHECK, SCAN, EMIT, DONE} state_t;
  state_t state;
  logic [31:0] src, dst;
  logic [2:0] x, y, cx, cy;
  logic [3:0] count;
  logic signed [7:0] board [64];
  logic signed [7:0] piece, tv;
  logic [5:0] idx, tgt, nidx;
  logic [1:0] dir;
  logic cont, busy, off;
  logic [4:0] nx, ny;
  logic unused_bits;
  assign unused_bits = ^master_readdata[31:8];
  assign busy = state != IDLE && state != DONE;
  // Host stalls only for a count read or any write while the engine runs
  always_comb begin
    slave_waitrequest = (slave_read && slave_address == 4'd0 && busy) || (slave_write && busy);
    slave_readdata = !slave_read ? 32'd0 :
                     slave_address == 4'd0 ? {28'd0, count} :
                     slave_address == 4'd1 ? src :
                     slave_address == 4'd2 ? dst :
                     slave_address == 4'd3 ? {29'd0, x} :
                     slave_address == 4'd4 ? {29'd0, y} : 32'd0;
  end
  // Next square along the current ray; 5-bit math makes -1 and 8 visible as off-board
  always_comb begin
    nx = {2'b00, cx} + (dir[0] ? 5'h1f : 5'h01);
    ny = {2'b00, cy} + (dir[1] ? 5'h1f : 5'h01);
    off = (|nx[4:3]) | (|ny[4:3]);
    nidx = {ny[2:0], nx[2:0]};
    tv = board[nidx];
  end
  function automatic logic [31:0] sq_data(input logic [5:0] i, input logic [5:0] t);
    logic signed [7:0] v;
    v = (i == {y, x}) ? 8'sd0 : (i == t) ? piece : board[i];
    return {{24{v[7]}}, v};
  endfunction
  // Control FSM: fetch, scan rays, emit boards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      src <= '0;
      dst <= '0;
      x <= '0;
      y <= '0;
      cx <= '0;
      cy <= '0;
      count <= '0;
      piece <= '0;
      idx <= '0;
      tgt <= '0;
      dir <= '0;
      cont <= 1'b0;
      master_read <= 1'b0;
      master_write <= 1'b0;
      master_address <= '0;
      master_writedata <= '0;
      for (int i = 0; i < 64; i++) board[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (slave_write) begin
          if (slave_address == 4'd0) begin
            state <= FETCH;
            idx <= '0;
            count <= '0;
            master_read <= 1'b1;
            master_address <= src;
          end
          if (slave_address == 4'd1) src <= slave_writedata;
          if (slave_address == 4'd2) dst <= slave_writedata;
          if (slave_address == 4'd3) x <= slave_writedata[2:0];
          if (slave_address == 4'd4) y <= slave_writedata[2:0];
        end
        FETCH: if (!master_waitrequest) begin
          master_read <= 1'b0;
          state <= FWAIT;
        end
        FWAIT: if (master_readdatavalid) begin
          board[idx] <= master_readdata[7:0];
          idx <= idx + 6'd1;
          if (idx == 6'd63) state <= CHECK;
          else begin
            master_read <= 1'b1;
            master_address <= src + {26'd0, idx} + 32'd1;
            state <= FETCH;
          end
        end
        CHECK: begin
          piece <= board[{y, x}];
          dir <= '0;
          cx <= x;
          cy <= y;
          state <= board[{y, x}] == 8'sd0 ? DONE : SCAN;
        end
        SCAN: if (off || (tv != 8'sd0 && tv[7] == piece[7])) begin
          if (dir == 2'd3) state <= DONE;
          else begin
            dir <= dir + 2'd1;
            cx <= x;
            cy <= y;
          end
        end else begin
          tgt <= nidx;
          cont <= tv == 8'sd0;
          cx <= nx[2:0];
          cy <= ny[2:0];
          idx <= '0;
          master_write <= 1'b1;
          master_address <= dst + {22'd0, count, 6'd0};
          master_writedata <= sq_data(6'd0, nidx);
          state <= EMIT;
        end
        EMIT: if (!master_waitrequest) begin
          if (idx == 6'd63) begin
            master_write <= 1'b0;
            count <= count + 4'd1;
            if (cont) state <= SCAN;
            else if (dir == 2'd3) state <= DONE;
            else begin
              dir <= dir + 2'd1;
              cx <= x;
              cy <= y;
              state <= SCAN;
            end
          end else begin
            idx <= idx + 6'd1;
            master_address <= master_address + 32'd1;
            master_writedata <= sq_data(idx + 6'd1, tgt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bishop.sv
// tb_bishop: randomized memory model and move-list reference for the bishop generator
module tb_bishop;
  logic clk = 0, rst_n = 0;
  logic slave_waitrequest, slave_read = 0, slave_write = 0;
  logic [3:0] slave_address = 0;
  logic [31:0] slave_readdata, slave_writedata = 0;
  logic master_waitrequest = 0, master_read, master_readdatavalid = 0, master_write;
  logic [31:0] master_address, master_readdata = 0, master_writedata;
  always #5 clk = ~clk;

  bishop dut (
    .clk(clk), .rst_n(rst_n),
    .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
    .slave_read(slave_read), .slave_readdata(slave_readdata),
    .slave_write(slave_write), .slave_writedata(slave_writedata),
    .master_waitrequest(master_waitrequest), .master_address(master_address),
    .master_read(master_read), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid), .master_write(master_write),
    .master_writedata(master_writedata)
  );

  int errors = 0, checks = 0;
  logic signed [7:0] bd [64];
  logic [31:0] src_a = 0, dst_a = 0, pend_addr = 0, offs, rdv, cnt;
  logic rw, stall_en = 0, delay_en = 0, wr_n;
  int pend = 0;
  logic [31:0] wa_q[$], wd_q[$];
  int exp_t[$];

  // Memory slave: random stalls, delayed read data, write log
  always @(negedge clk) begin
    master_readdatavalid = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        offs = pend_addr - src_a;
        master_readdatavalid = 1;
        master_readdata = {24'($urandom()), bd[offs[5:0]]};
      end
    end
    wr_n = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    master_waitrequest = wr_n;
    if (rst_n && master_read && !wr_n) begin
      pend = delay_en ? $urandom_range(1, 3) : 1;
      pend_addr = master_address;
    end
    if (rst_n && master_write && !wr_n) begin
      wa_q.push_back(master_address);
      wd_q.push_back(master_writedata);
    end
  end

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_address = a;
    slave_writedata = d;
    slave_write = 1;
    @(negedge clk);
    slave_write = 0;
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [31:0] d, output logic w);
    @(negedge clk);
    slave_address = a;
    slave_read = 1;
    #1 d = slave_readdata;
    w = slave_waitrequest;
    slave_read = 0;
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) bd[i] = 0;
  endtask

  task automatic start_run(input int x, input int y, input logic [31:0] s, input logic [31:0] d);
    wa_q.delete();
    wd_q.delete();
    src_a = s;
    dst_a = d;
    wr_reg(1, s);
    wr_reg(2, d);
    wr_reg(3, 32'(x));
    wr_reg(4, 32'(y));
    wr_reg(0, 0);
  endtask

  task automatic wait_done(output logic [31:0] c);
    int n = 0;
    rw = 1;
    while (rw && n < 20000) begin
      rd_reg(0, rdv, rw);
      n++;
    end
    checks++;
    if (rw) begin
      errors++;
      $display("FAIL done_timeout: waitrequest still %0b after %0d polls, required 0", rw, n);
    end
    c = rdv;
  endtask

  // Reference: walk each ray over the board with plain coordinates
  task automatic model(input int x, input int y);
    int p, cx, cy, dx, dy, v;
    exp_t.delete();
    p = bd[y*8+x];
    if (p == 0) return;
    for (int d = 0; d < 4; d++) begin
      dx = (d % 2 == 0) ? 1 : -1;
      dy = (d < 2) ? 1 : -1;
      cx = x + dx;
      cy = y + dy;
      while (cx >= 0 && cx < 8 && cy >= 0 && cy < 8) begin
        v = bd[cy*8+cx];
        if (v == 0) exp_t.push_back(cy*8+cx);
        else begin
          if ((v > 0) != (p > 0)) exp_t.push_back(cy*8+cx);
          break;
        end
        cx += dx;
        cy += dy;
      end
    end
  endtask

  task automatic check_run(input string nm, input int x, input int y, input logic [31:0] c);
    int p, bad;
    logic signed [7:0] v;
    logic [31:0] ea, ed;
    model(x, y);
    p = bd[y*8+x];
    checks++;
    if (c !== 32'(exp_t.size())) begin
      errors++;
      $display("FAIL %s count: got %0d expected %0d", nm, c, exp_t.size());
    end
    checks++;
    if (wa_q.size() != exp_t.size() * 64) begin
      errors++;
      $display("FAIL %s writes: got %0d expected %0d", nm, wa_q.size(), exp_t.size() * 64);
    end else
      for (int k = 0; k < exp_t.size(); k++) begin
        bad = -1;
        for (int i = 0; i < 64; i++) begin
          v = (i == y*8+x) ? 8'sd0 : (i == exp_t[k]) ? 8'(p) : bd[i];
          ea = dst_a + 32'(k*64 + i);
          ed = 32'(int'(v));
          if (bad < 0 && (wa_q[k*64+i] !== ea || wd_q[k*64+i] !== ed)) bad = i;
        end
        checks++;
        if (bad >= 0) begin
          errors++;
          $display("FAIL %s board%0d sq%0d: got addr=%h data=%h expected addr=%h data=%h", nm, k, bad,
                   wa_q[k*64+bad], wd_q[k*64+bad], dst_a + 32'(k*64+bad),
                   32'(int'((bad == y*8+x) ? 8'sd0 : (bad == exp_t[k]) ? 8'(p) : bd[bad])));
        end
      end
  endtask

  function automatic int dut_target(input int k, input logic [31:0] val);
    for (int i = 0; i < 64; i++) if (k*64+i < wd_q.size() && wd_q[k*64+i] === val) return i;
    return -1;
  endfunction

  task automatic test_reset();
    checks++;
    if (master_read !== 0 || master_write !== 0 || master_address !== 0 || slave_waitrequest !== 0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h wait=%b expected 0 0 0 0",
               master_read, master_write, master_address, slave_waitrequest);
    end
    rd_reg(0, rdv, rw);
    checks++;
    if (rdv !== 0 || rw !== 0) begin
      errors++;
      $display("FAIL reset_count: got %0d wait=%b expected 0 0", rdv, rw);
    end
  endtask

  task automatic test_center(input logic stalls);
    int order[11] = '{38, 47, 36, 43, 50, 57, 22, 15, 20, 11, 2};
    int t;
    stall_en = stalls;
    delay_en = stalls;
    clear_board();
    bd[29] = 29;
    start_run(5, 3, 32'h1000, 32'h2000);
    wait_done(cnt);
    check_run(stalls ? "center_stall" : "center", 5, 3, cnt);
    checks++;
    if (cnt !== 11) begin
      errors++;
      $display("FAIL center_reg0: got %0d expected 11", cnt);
    end
    for (int k = 0; k < 11; k++) begin
      t = dut_target(k, 32'd29);
      checks++;
      if (t != order[k]) begin
        errors++;
        $display("FAIL center_order board%0d: got target %0d expected %0d", k, t, order[k]);
      end
    end
    checks++;
    if (wd_q.size() < 64 || wd_q[29] !== 0) begin
      errors++;
      $display("FAIL center_src_cleared: got %h expected 0", wd_q.size() < 64 ? 32'hx : wd_q[29]);
    end
    stall_en = 0;
    delay_en = 0;
  endtask

  task automatic test_capture();
    int t;
    clear_board();
    bd[29] = 29;
    bd[38] = 1;
    bd[20] = -1;
    start_run(5, 3, 32'h3000, 32'h4000);
    wait_done(cnt);
    check_run("capture", 5, 3, cnt);
    for (int k = 0; k < cnt; k++) begin
      t = dut_target(k, 32'd29);
      checks++;
      if (t == 38 || t == 47 || t < 0) begin
        errors++;
        $display("FAIL capture_blocked board%0d: got target %0d expected not 38/47", k, t);
      end
    end
    t = (cnt > 0) ? dut_target(int'(cnt) - 1, 32'd29) : -1;
    checks++;
    if (t != 20) begin
      errors++;
      $display("FAIL capture_last: got target %0d expected 20", t);
    end
  endtask

  task automatic test_empty_source();
    clear_board();
    start_run(0, 0, 32'h1000, 32'h2000);
    wait_done(cnt);
    check_run("empty", 0, 0, cnt);
    checks++;
    if (cnt !== 0 || wa_q.size() != 0) begin
      errors++;
      $display("FAIL empty_none: got count=%0d writes=%0d expected 0 0", cnt, wa_q.size());
    end
  endtask

  task automatic test_corner();
    int t;
    clear_board();
    bd[0] = 29;
    start_run(0, 0, 32'h5000, 32'hFFFF_FF00);
    checks++;
    rd_reg(0, rdv, rw);
    if (rw !== 1) begin
      errors++;
      $display("FAIL busy_read_wait: got %b expected 1", rw);
    end
    @(negedge clk);
    slave_address = 1;
    slave_write = 1;
    #1 checks++;
    if (slave_waitrequest !== 1) begin
      errors++;
      $display("FAIL busy_write_wait: got %b expected 1", slave_waitrequest);
    end
    slave_write = 0;
    wait_done(cnt);
    check_run("corner", 0, 0, cnt);
    for (int k = 0; k < 7; k++) begin
      t = dut_target(k, 32'd29);
      checks++;
      if (t != 9 * (k + 1)) begin
        errors++;
        $display("FAIL corner_target board%0d: got %0d expected %0d", k, t, 9 * (k + 1));
      end
    end
  endtask

  task automatic test_random();
    int x, y, m;
    stall_en = 1;
    delay_en = 1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 64; i++) begin
        m = $urandom_range(1, 6);
        bd[i] = $urandom_range(0, 1) ? 8'sd0 : ($urandom_range(0, 1) ? 8'(m) : 8'(-m));
      end
      x = $urandom_range(0, 7);
      y = $urandom_range(0, 7);
      bd[y*8+x] = $urandom_range(0, 1) ? 8'sd3 : -8'sd3;
      start_run(x, y, $urandom(), $urandom());
      wait_done(cnt);
      check_run("random", x, y, cnt);
    end
    stall_en = 0;
    delay_en = 0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_board();
    bd[29] = 29;
    start_run(5, 3, 32'h1000, 32'h2000);
    while (!master_write && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!master_write) begin
      errors++;
      $display("FAIL rstmid_emit_seen: got write=%b expected 1", master_write);
    end
    repeat (20) @(negedge clk);
    #2 rst_n = 0;
    #1 checks++;
    if (master_write !== 0 || master_read !== 0) begin
      errors++;
      $display("FAIL rstmid_strobes: got wr=%b rd=%b expected 0 0", master_write, master_read);
    end
    rd_reg(0, rdv, rw);
    checks++;
    if (rdv !== 0 || rw !== 0) begin
      errors++;
      $display("FAIL rstmid_count: got %0d wait=%b expected 0 0", rdv, rw);
    end
    @(negedge clk);
    rst_n = 1;
    start_run(5, 3, 32'h1000, 32'h2000);
    wait_done(cnt);
    check_run("rstmid_rerun", 5, 3, cnt);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    test_reset();
    test_center(0);
    test_center(1);
    test_capture();
    test_empty_source();
    test_corner();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
